// File: rtl/dff_pkg.sv
// Shared constants and helpers for the dff_pipe register pipeline.
package dff_pkg;

  localparam int unsigned DFF_RESET_VAL = 32'd0;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: WIDTH-bit data word plus valid flag, with enable,
// synchronous clear and asynchronous active-low reset.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_RESET_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // Stage register: clear has priority over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q       <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (clr) begin
      q       <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end else begin
      q       <= q;
      q_valid <= q_valid;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage enabled shift pipeline with flush and a registered count of
// stages currently holding valid data.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_RESET_VAL),
  localparam int              OCC_W     = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [OCC_W-1:0] occ
);

  logic [WIDTH-1:0] stage_d_s [DEPTH];
  logic [DEPTH-1:0] stage_v_s;
  logic [OCC_W-1:0] occ_r;
  logic [OCC_W-1:0] occ_next_s;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] in_d_s;
    logic             in_v_s;

    if (i == 0) begin : g_head
      assign in_d_s = d;
      assign in_v_s = d_valid;
    end else begin : g_body
      assign in_d_s = stage_d_s[i-1];
      assign in_v_s = stage_v_s[i-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clr     (flush),
      .d       (in_d_s),
      .d_valid (in_v_s),
      .q       (stage_d_s[i]),
      .q_valid (stage_v_s[i])
    );
  end

  // Occupancy tracks words entering stage 0 and leaving the last stage;
  // modular arithmetic is safe because the true count stays within 0..DEPTH.
  always_comb begin
    occ_next_s = occ_r;
    if (flush) begin
      occ_next_s = {OCC_W{1'b0}};
    end else if (en) begin
      occ_next_s = occ_r + OCC_W'(d_valid) - OCC_W'(stage_v_s[DEPTH-1]);
    end else begin
      occ_next_s = occ_r;
    end
  end

  // Occupancy register, updated on the same edge as the stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_r <= {OCC_W{1'b0}};
    end else begin
      occ_r <= occ_next_s;
    end
  end

  assign q       = stage_d_s[DEPTH-1];
  assign q_valid = stage_v_s[DEPTH-1];
  assign occ     = occ_r;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: directed scenarios plus a random run
// against an array-based reference model, on DEPTH=4 and DEPTH=1 instances.
module tb_dff_pipe;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         flush;
  logic [W-1:0] d;
  logic         d_valid;
  logic [W-1:0] q4;
  logic         qv4;
  logic [2:0]   occ4;
  logic [W-1:0] q1;
  logic         qv1;
  logic [0:0]   occ1;

  int checks = 0;
  int errors = 0;

  dff_pipe #(.WIDTH(W), .DEPTH(D)) dut4 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q4), .q_valid(qv4), .occ(occ4)
  );

  dff_pipe #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
    .q(q1), .q_valid(qv1), .occ(occ1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: arrays of words and valid flags, index 0 = newest.
  logic [W-1:0] m_d [D];
  logic         m_v [D];
  logic [W-1:0] m1_d;
  logic         m1_v;

  always @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      for (int i = 0; i < D; i++) begin
        m_d[i] <= 8'h00;
        m_v[i] <= 1'b0;
      end
      m1_d <= 8'h00;
      m1_v <= 1'b0;
    end else if (en) begin
      for (int i = D - 1; i > 0; i--) begin
        m_d[i] <= m_d[i-1];
        m_v[i] <= m_v[i-1];
      end
      m_d[0] <= d;
      m_v[0] <= d_valid;
      m1_d   <= d;
      m1_v   <= d_valid;
    end
  end

  function automatic int pop4();
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(m_v[i]);
    return n;
  endfunction

  // Every falling edge: both instances against the model, occ against popcount.
  always @(negedge clk) begin
    checks++;
    if (q4 !== m_d[D-1] || qv4 !== m_v[D-1] || int'(occ4) != pop4()) begin
      errors++;
      $display("FAIL model4 t=%0t: got q=%h qv=%b occ=%0d, want q=%h qv=%b occ=%0d",
               $time, q4, qv4, occ4, m_d[D-1], m_v[D-1], pop4());
    end
    checks++;
    if (q1 !== m1_d || qv1 !== m1_v || occ1 !== m1_v) begin
      errors++;
      $display("FAIL model1 t=%0t: got q=%h qv=%b occ=%0d, want q=%h qv=%b occ=%0d",
               $time, q1, qv1, occ1, m1_d, m1_v, m1_v);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    en = 1'b0; d_valid = 1'b0; d = 8'h00; flush = 1'b1;
    tick(1);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    tick(1);
    checks++;
    if (q4 !== 8'h00 || qv4 !== 1'b0 || occ4 !== 3'd0) begin
      errors++;
      $display("FAIL reset_init: got q=%h qv=%b occ=%0d, want 00 0 0", q4, qv4, occ4);
    end
    rst = 1'b1;
    en = 1'b1; d_valid = 1'b1; d = 8'hAA;
    tick(4);
    checks++;
    if (q4 !== 8'hAA || qv4 !== 1'b1 || occ4 !== 3'd4) begin
      errors++;
      $display("FAIL reset_fill: got q=%h qv=%b occ=%0d, want aa 1 4", q4, qv4, occ4);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (q4 !== 8'h00 || qv4 !== 1'b0 || occ4 !== 3'd0 || q1 !== 8'h00 || qv1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got q=%h qv=%b occ=%0d q1=%h, want 00 0 0 00", q4, qv4, occ4, q1);
    end
    flush = 1'b1;
    tick(2);
    flush = 1'b0;
    checks++;
    if (q4 !== 8'h00 || qv4 !== 1'b0 || occ4 !== 3'd0 || qv1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got q=%h qv=%b occ=%0d, want 00 0 0", q4, qv4, occ4);
    end
    #2 rst = 1'b1;
    d = 8'h3C;
    tick(1);
    checks++;
    if (occ4 !== 3'd1 || qv4 !== 1'b0 || q1 !== 8'h3C) begin
      errors++;
      $display("FAIL reset_release: got occ=%0d qv=%b q1=%h, want 1 0 3c", occ4, qv4, q1);
    end
    do_flush();
  endtask

  task automatic test_latency();
    logic [W-1:0] exp_q [3] = '{8'h01, 8'h02, 8'h03};
    do_flush();
    en = 1'b1; d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = exp_q[i];
      tick(1);
      checks++;
      if (occ4 !== 3'(i + 1) || qv4 !== 1'b0) begin
        errors++;
        $display("FAIL latency_fill%0d: got occ=%0d qv=%b, want %0d 0", i, occ4, qv4, i + 1);
      end
    end
    d_valid = 1'b0; d = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (q4 !== exp_q[i] || qv4 !== 1'b1 || occ4 !== 3'(3 - i)) begin
        errors++;
        $display("FAIL latency_out%0d: got q=%h qv=%b occ=%0d, want %h 1 %0d",
                 i, q4, qv4, occ4, exp_q[i], 3 - i);
      end
    end
    tick(1);
    checks++;
    if (qv4 !== 1'b0 || occ4 !== 3'd0) begin
      errors++;
      $display("FAIL latency_drain: got qv=%b occ=%0d, want 0 0", qv4, occ4);
    end
  endtask

  task automatic test_stall();
    do_flush();
    en = 1'b1; d_valid = 1'b1; d = 8'h11;
    tick(1);
    d = 8'h22;
    tick(1);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      d_valid = 1'($urandom);
      tick(1);
      checks++;
      if (q4 !== 8'h00 || qv4 !== 1'b0 || occ4 !== 3'd2) begin
        errors++;
        $display("FAIL stall_hold%0d: got q=%h qv=%b occ=%0d, want 00 0 2", i, q4, qv4, occ4);
      end
    end
    en = 1'b1; d_valid = 1'b0; d = 8'h00;
    tick(1);
    checks++;
    if (qv4 !== 1'b0) begin
      errors++;
      $display("FAIL stall_early: got qv=%b, want 0", qv4);
    end
    tick(1);
    checks++;
    if (q4 !== 8'h11 || qv4 !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume: got q=%h qv=%b, want 11 1", q4, qv4);
    end
    tick(1);
    checks++;
    if (q4 !== 8'h22 || qv4 !== 1'b1 || occ4 !== 3'd1) begin
      errors++;
      $display("FAIL stall_second: got q=%h qv=%b occ=%0d, want 22 1 1", q4, qv4, occ4);
    end
  endtask

  task automatic test_flush();
    do_flush();
    en = 1'b1; d_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d = 8'hA1 + 8'(i);
      tick(1);
    end
    flush = 1'b1; d = 8'h55;
    tick(1);
    flush = 1'b0;
    checks++;
    if (occ4 !== 3'd0 || qv4 !== 1'b0 || q4 !== 8'h00) begin
      errors++;
      $display("FAIL flush_clear: got q=%h qv=%b occ=%0d, want 00 0 0", q4, qv4, occ4);
    end
    d_valid = 1'b0; d = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (q4 !== 8'h00 || qv4 !== 1'b0) begin
        errors++;
        $display("FAIL flush_discard%0d: got q=%h qv=%b, want 00 0", i, q4, qv4);
      end
    end
  endtask

  task automatic test_full();
    do_flush();
    en = 1'b1; d_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      d = 8'hB0 + 8'(i);
      tick(1);
      if (i >= 3) begin
        checks++;
        if (occ4 !== 3'd4 || q4 !== 8'hB0 + 8'(i - 3) || qv4 !== 1'b1) begin
          errors++;
          $display("FAIL full_steady%0d: got q=%h qv=%b occ=%0d, want %h 1 4",
                   i, q4, qv4, occ4, 8'hB0 + 8'(i - 3));
        end
      end
    end
  endtask

  task automatic test_depth1();
    do_flush();
    en = 1'b1; d_valid = 1'b1; d = 8'h7E;
    tick(1);
    checks++;
    if (q1 !== 8'h7E || qv1 !== 1'b1 || occ1 !== 1'b1) begin
      errors++;
      $display("FAIL depth1_load: got q=%h qv=%b occ=%0d, want 7e 1 1", q1, qv1, occ1);
    end
    en = 1'b0; d_valid = 1'b0; d = 8'h00;
    tick(1);
    checks++;
    if (q1 !== 8'h7E || qv1 !== 1'b1 || occ1 !== 1'b1) begin
      errors++;
      $display("FAIL depth1_hold: got q=%h qv=%b occ=%0d, want 7e 1 1", q1, qv1, occ1);
    end
    en = 1'b1;
    tick(1);
    checks++;
    if (q1 !== 8'h00 || qv1 !== 1'b0 || occ1 !== 1'b0) begin
      errors++;
      $display("FAIL depth1_drain: got q=%h qv=%b occ=%0d, want 00 0 0", q1, qv1, occ1);
    end
  endtask

  task automatic test_random();
    do_flush();
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 9) < 7);
      flush   = ($urandom_range(0, 19) == 0);
      d_valid = 1'($urandom);
      d       = 8'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b0;
        #1 rst = 1'b1;
      end
      tick(1);
    end
    flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; flush = 1'b0; d = 8'h00; d_valid = 1'b0;
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_full();
    test_depth1();
    test_random();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001: Parameter WIDTH, default 8, data bits per stage (>=1).
REQ-002: Parameter DEPTH, default 4, number of register stages (>=1).
REQ-003: Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every data stage on reset and on flush.
REQ-004: clk  input  1  sole clock; all state updates on rising edge.
REQ-005: rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-006: en  input  1  advance enable; 1 = pipeline shifts one stage this edge, 0 = hold.
REQ-007: flush  input  1  synchronous clear of all stages.
REQ-008: d  input  WIDTH  data into stage 0.
REQ-009: d_valid  input  1  qualifies d.
REQ-010: q  output  WIDTH  data of stage DEPTH-1, registered.
REQ-011: q_valid  output  1  valid bit of stage DEPTH-1, registered.
REQ-012: occ  output  $clog2(DEPTH+1)  count of stages currently holding valid data, registered.

Function
REQ-013: Each stage SHALL hold a WIDTH-bit data word and a 1-bit valid flag.
REQ-014: On a rising edge with flush=0 and en=1, stage 0 SHALL capture {d, d_valid}, and stage i SHALL capture stage i-1 for 1<=i<DEPTH.
REQ-015: On a rising edge with flush=0 and en=0, every stage SHALL hold its data and valid unchanged, regardless of d and d_valid.
REQ-016: Latency SHALL be exactly DEPTH enabled edges from d capture to appearance on q; non-enabled edges do not count.
REQ-017: Stages with valid=0 SHALL still shift their data; q SHALL show stage DEPTH-1 data whatever q_valid is.
REQ-018: On a rising edge with flush=1, every data stage SHALL load RESET_VAL and every valid SHALL clear, and occ SHALL become 0, whatever en is.
REQ-019: flush and en/d_valid asserted together: flush SHALL win and the incoming word SHALL be discarded.
REQ-020: occ SHALL update on the same edge as the stages: occ_next = occ + (en & d_valid) - (en & q_valid) when flush=0.
REQ-021: occ SHALL always equal the population count of the stage valid bits; it SHALL never exceed DEPTH and never underflow.
REQ-022: When the pipe is full (occ=DEPTH) and en=1 with d_valid=1, occ SHALL stay DEPTH, since one word enters and one leaves.
REQ-023: For DEPTH=1, q/q_valid SHALL be stage 0 and occ SHALL be 1 bit wide; all rules above still apply.
REQ-024: No output SHALL depend combinationally on any input.

Reset
REQ-025: rst=0 SHALL immediately, without waiting for a clock edge, force every data stage to RESET_VAL, every valid to 0, q=RESET_VAL, q_valid=0 and occ=0.
REQ-026: Reset asserted mid-operation SHALL discard all in-flight words; after release the first enabled edge SHALL load stage 0 only.
REQ-027: While rst=0, en, flush, d and d_valid SHALL be ignored.

Structure
REQ-028: The width-of-occ helper ($clog2(DEPTH+1)) and the default RESET_VAL SHALL live in shared package dff_pkg.
REQ-029: One sub-module dff_stage (WIDTH-bit data plus valid register, with enable, synchronous clear and asynchronous active-low reset) SHALL be instantiated DEPTH times via generate.
REQ-030: The occ counter SHALL be a separate register in dff_pipe, not recomputed combinationally from the valid bits.

Verification
REQ-031: Reset: assert rst=0 between edges with the pipe full of 0xAA -> q=0x00, q_valid=0, occ=0 immediately, before the next edge.
REQ-032: Latency: WIDTH=8, DEPTH=4, en=1, feed d_valid=1 with 0x01,0x02,0x03 on consecutive edges -> q=0x01 with q_valid=1 on the 4th edge after 0x01 was sampled, then 0x02 and 0x03 on the following edges; occ peaks at 3 and returns to 0.
REQ-033: Stall: load 0x11 and 0x22, hold en=0 for 5 edges while toggling d -> q, q_valid and occ unchanged; after en=1 resumes, 0x11 arrives after the remaining enabled edges only.
REQ-034: Flush priority: pipe holding 3 valid words, drive flush=1, en=1, d_valid=1, d=0x55 -> next edge occ=0, q_valid=0, q=RESET_VAL, and 0x55 never appears on q.
REQ-035: Full steady state: fill with 4 valid words, keep en=1, d_valid=1 for 10 edges -> occ stays 4 and q sequence matches input delayed by 4.
REQ-036: DEPTH=1 instance: en=1, d=0x7E, d_valid=1 -> q=0x7E, q_valid=1, occ=1 after one edge; occ equals the popcount of valid bits on every edge in all scenarios.
